offchip_mem_arbiter: RTL and testbench
======================================

// Module: offchip_mem_arbiter
// PURPOSE
//  Shares the single off-chip memory line port between the I-cache refill path and the D-cache refill/writeback path.
//  Round-robin arbitration; one line transfer in flight at a time.
//  Drives offchip_mem_read_en/write_en/addr/wdata; captures offchip_mem_data on offchip_mem_ready.
//  Sits in cpu_pipeline between the cache controllers and the off-chip memory pins.
// PARAMETERS
//  LINE_BYTES      16   line size in bytes (= `CACHE_LINE_SIZE); power of two
//  ADDR_W          32   address width (= `MAX_BIT_POS+1)
//  TIMEOUT_CYCLES  64   watchdog limit in ISSUE; used only with OFFCHIP_ARB_TIMEOUT_EN
// PORTS
//  clk                   in   1              core clock
//  rst_n                 in   1              synchronous active-low reset
//  ic_req                in   1              I-cache line read request
//  ic_addr               in   ADDR_W         I-cache line address
//  ic_rdata              out  LINE_BYTES*8   line data to I-cache
//  ic_done               out  1              1-cycle completion pulse to I-cache
//  ic_err                out  1              I-cache transfer timed out (valid with ic_done)
//  dc_req                in   1              D-cache request
//  dc_we                 in   1              1 = line writeback, 0 = line read
//  dc_addr               in   ADDR_W         D-cache line address
//  dc_wdata              in   LINE_BYTES*8   writeback line data
//  dc_rdata              out  LINE_BYTES*8   line data to D-cache
//  dc_done               out  1              1-cycle completion pulse to D-cache
//  dc_err                out  1              D-cache transfer timed out (valid with dc_done)
//  offchip_mem_data      in   LINE_BYTES*8   read line from memory
//  offchip_mem_ready     in   1              memory completion; high 1+ cycles
//  offchip_mem_read_en   out  1              read strobe
//  offchip_mem_write_en  out  1              write strobe
//  offchip_mem_addr      out  ADDR_W         line-aligned address
//  offchip_mem_wdata     out  LINE_BYTES*8   write line
// BEHAVIOUR
//  - All outputs registered. Reset: every *_en, *_done, *_err = 0; addr, wdata, rdata = 0; FSM = IDLE; rr_last = IC (D-cache wins first tie).
//  - FSM IDLE -> ISSUE -> RELEASE -> IDLE.
//  - IDLE: any req at edge N -> grant and latch addr/we/wdata.
//    - One requester: that requester is granted.
//    - Both: the one not equal to rr_last; rr_last updates to the granted requester.
//    - Edge N also sets the strobe: read_en, or write_en if D-cache with dc_we=1. Never both.
//    - addr = req addr with low log2(LINE_BYTES) bits forced 0.
//  - ISSUE: strobe and addr/wdata held stable. offchip_mem_ready sampled high at edge M:
//    - strobe cleared.
//    - For reads, granted *_rdata <= offchip_mem_data.
//    - Granted *_done = 1 for exactly one cycle after edge M.
//    - Go RELEASE.
//  - RELEASE: stay until offchip_mem_ready sampled low, then IDLE. This guarantees a strobe low gap before any new posedge.
//  - Minimum turnaround: req -> strobe 1 cycle; ready -> done 1 cycle; back-to-back transfers at least 1 idle strobe cycle apart.
//  - *_rdata holds its last value until the next read for that requester. Writebacks leave dc_rdata unchanged.
//  - Requester contract:
//    - Hold req/addr/data stable until done.
//    - Drop req on or before the edge that samples done.
//    - The arbiter ignores req outside IDLE.
//  - offchip_mem_ready high while in IDLE (spurious) is ignored.
//  - Reset mid-transfer: next edge with rst_n=0 forces reset values. No done is issued for the aborted transfer.
// CONFIGURATION
//  - OFFCHIP_ARB_TIMEOUT_EN defined:
//    - 8-bit+ counter cleared on entering ISSUE, increments each ISSUE cycle.
//    - On reaching TIMEOUT_CYCLES with no ready: strobe cleared; granted done=1 and err=1 for one cycle; rdata set to 0; go RELEASE.
//    - ready arriving on the same edge as expiry wins (normal completion, err=0).
//  - Undefined: no counter; ISSUE waits indefinitely; ic_err/dc_err tied 0.
// TESTING
//  1. I-cache only: ic_addr=0x0000_0013; memory returns ready 2 cycles later with data 0x0F0E..0100
//     -> read_en high 1 cycle after req; addr=0x10; ic_rdata=0x0F0E..0100; ic_done pulses once; write_en never high.
//  2. Simultaneous ic_req and dc_req (read) after reset
//     -> D-cache served first, then I-cache.
//     -> Repeat the pair -> order D,I,D,I alternates per rr_last.
//  3. D-cache writeback, dc_addr=0x24, dc_wdata=pattern A
//     -> write_en=1, addr=0x20, wdata=A until ready; dc_done pulse; dc_rdata unchanged.
//  4. Memory holds ready 2 cycles while ic_req pending
//     -> exactly one ic_done.
//     -> Next read_en rises only after ready sampled low (strobe gap >= 1 cycle).
//  5. rst_n low for one cycle while in ISSUE
//     -> read_en/write_en 0 next cycle; no done.
//     -> Post-reset tie -> D-cache granted.
//  6. With OFFCHIP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never asserted
//     -> dc_done=dc_err=1 exactly 8 cycles after ISSUE entry; dc_rdata=0.
//     -> Without the macro: no done after 100 cycles.

Source files
------------

// File: rtl/offchip_mem_arbiter.sv
// Round-robin arbiter sharing the off-chip line port between I-cache refill and D-cache refill/writeback.
// Optional ISSUE watchdog enabled by defining OFFCHIP_ARB_TIMEOUT_EN.
module offchip_mem_arbiter #(
    parameter int LINE_BYTES     = 16,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ic_req,
    input  logic [ADDR_W-1:0]         ic_addr,
    output logic [LINE_BYTES*8-1:0]   ic_rdata,
    output logic                      ic_done,
    output logic                      ic_err,
    input  logic                      dc_req,
    input  logic                      dc_we,
    input  logic [ADDR_W-1:0]         dc_addr,
    input  logic [LINE_BYTES*8-1:0]   dc_wdata,
    output logic [LINE_BYTES*8-1:0]   dc_rdata,
    output logic                      dc_done,
    output logic                      dc_err,
    input  logic [LINE_BYTES*8-1:0]   offchip_mem_data,
    input  logic                      offchip_mem_ready,
    output logic                      offchip_mem_read_en,
    output logic                      offchip_mem_write_en,
    output logic [ADDR_W-1:0]         offchip_mem_addr,
    output logic [LINE_BYTES*8-1:0]   offchip_mem_wdata
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LINE_BYTES - 1));

    if ((LINE_BYTES & (LINE_BYTES - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("offchip_mem_arbiter: LINE_BYTES must be a power of two and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              gnt_dc, gnt_dc_nxt;
    logic              gnt_wr, gnt_wr_nxt;
    logic              rr_last_dc, rr_last_dc_nxt;   // 0 = I-cache was granted last
    logic              read_en_nxt, write_en_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LINE_W-1:0] wdata_nxt;
    logic [LINE_W-1:0] ic_rdata_nxt, dc_rdata_nxt;
    logic              ic_done_nxt, dc_done_nxt;
    logic              ic_err_nxt, dc_err_nxt;
    logic              pick_dc;

`ifdef OFFCHIP_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            gnt_dc               <= 1'b0;
            gnt_wr               <= 1'b0;
            rr_last_dc           <= 1'b0;
            offchip_mem_read_en  <= 1'b0;
            offchip_mem_write_en <= 1'b0;
            offchip_mem_addr     <= '0;
            offchip_mem_wdata    <= '0;
            ic_rdata             <= '0;
            dc_rdata             <= '0;
            ic_done              <= 1'b0;
            dc_done              <= 1'b0;
            ic_err               <= 1'b0;
            dc_err               <= 1'b0;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
            wd_cnt               <= '0;
`endif
        end else begin
            state                <= state_nxt;
            gnt_dc               <= gnt_dc_nxt;
            gnt_wr               <= gnt_wr_nxt;
            rr_last_dc           <= rr_last_dc_nxt;
            offchip_mem_read_en  <= read_en_nxt;
            offchip_mem_write_en <= write_en_nxt;
            offchip_mem_addr     <= addr_nxt;
            offchip_mem_wdata    <= wdata_nxt;
            ic_rdata             <= ic_rdata_nxt;
            dc_rdata             <= dc_rdata_nxt;
            ic_done              <= ic_done_nxt;
            dc_done              <= dc_done_nxt;
            ic_err               <= ic_err_nxt;
            dc_err               <= dc_err_nxt;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
            wd_cnt               <= wd_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        gnt_dc_nxt     = gnt_dc;
        gnt_wr_nxt     = gnt_wr;
        rr_last_dc_nxt = rr_last_dc;
        read_en_nxt    = offchip_mem_read_en;
        write_en_nxt   = offchip_mem_write_en;
        addr_nxt       = offchip_mem_addr;
        wdata_nxt      = offchip_mem_wdata;
        ic_rdata_nxt   = ic_rdata;
        dc_rdata_nxt   = dc_rdata;
        ic_done_nxt    = 1'b0;
        dc_done_nxt    = 1'b0;
        ic_err_nxt     = 1'b0;
        dc_err_nxt     = 1'b0;
        pick_dc        = 1'b0;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
        wd_cnt_nxt     = wd_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    // On a tie the requester not served last wins
                    pick_dc        = dc_req && (!ic_req || !rr_last_dc);
                    gnt_dc_nxt     = pick_dc;
                    gnt_wr_nxt     = pick_dc && dc_we;
                    rr_last_dc_nxt = pick_dc;
                    addr_nxt       = (pick_dc ? dc_addr : ic_addr) & ALIGN_MASK;
                    if (pick_dc && dc_we) begin
                        wdata_nxt = dc_wdata;
                    end
                    read_en_nxt    = !(pick_dc && dc_we);
                    write_en_nxt   = pick_dc && dc_we;
                    state_nxt      = S_ISSUE;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
                    wd_cnt_nxt     = '0;
`endif
                end
            end

            S_ISSUE: begin
                if (offchip_mem_ready) begin
                    read_en_nxt  = 1'b0;
                    write_en_nxt = 1'b0;
                    state_nxt    = S_RELEASE;
                    if (gnt_dc) begin
                        dc_done_nxt = 1'b1;
                        if (!gnt_wr) begin
                            dc_rdata_nxt = offchip_mem_data;
                        end
                    end else begin
                        ic_done_nxt  = 1'b1;
                        ic_rdata_nxt = offchip_mem_data;
                    end
                end
`ifdef OFFCHIP_ARB_TIMEOUT_EN
                else if (wd_cnt == CNT_LAST) begin
                    read_en_nxt  = 1'b0;
                    write_en_nxt = 1'b0;
                    state_nxt    = S_RELEASE;
                    if (gnt_dc) begin
                        dc_done_nxt = 1'b1;
                        dc_err_nxt  = 1'b1;
                        if (!gnt_wr) begin
                            dc_rdata_nxt = '0;
                        end
                    end else begin
                        ic_done_nxt  = 1'b1;
                        ic_err_nxt   = 1'b1;
                        ic_rdata_nxt = '0;
                    end
                end else begin
                    wd_cnt_nxt = wd_cnt + 1'b1;
                end
`endif
            end

            S_RELEASE: begin
                // Wait out ready so the next strobe always follows a low gap
                if (!offchip_mem_ready) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                read_en_nxt  = 1'b0;
                write_en_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Directed self-checking bench for offchip_mem_arbiter; timeout scenario follows OFFCHIP_ARB_TIMEOUT_EN.
module tb_offchip_mem_arbiter;

    localparam int LB = 16;
    localparam int AW = 32;
    localparam int LW = LB * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req, dc_req, dc_we;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [LW-1:0] dc_wdata, mem_data;
    logic          mem_ready;
    logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic          ic_done, ic_err, dc_done, dc_err;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [LW-1:0] IC_DATA0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [LW-1:0] D_DATA   = 128'hD0D0D0D0_11112222_33334444_55556666;
    localparam logic [LW-1:0] I_DATA   = 128'h1C1C1C1C_77778888_9999AAAA_BBBBCCCC;
    localparam logic [LW-1:0] PAT_A    = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;

    always #5 clk = ~clk;

    offchip_mem_arbiter #(.LINE_BYTES(LB), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_done(ic_done), .ic_err(ic_err),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_done(dc_done), .dc_err(dc_err),
        .offchip_mem_data(mem_data), .offchip_mem_ready(mem_ready),
        .offchip_mem_read_en(mem_rd), .offchip_mem_write_en(mem_wr),
        .offchip_mem_addr(mem_addr), .offchip_mem_wdata(mem_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) $display("FAIL reset_strobes: rd=%b wr=%b want 0 0", mem_rd, mem_wr);
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_addr_wdata: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (ic_rdata !== '0 || dc_rdata !== '0) $display("FAIL reset_rdata: ic=%h dc=%h want 0", ic_rdata, dc_rdata);
        else n_pass++;
        n_checks++;
        if ({ic_done, dc_done, ic_err, dc_err} !== 4'b0) $display("FAIL reset_done_err: got %b want 0000", {ic_done, dc_done, ic_err, dc_err});
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ic_only();
        int wr_seen = 0;
        ic_req  = 1'b1;
        ic_addr = 32'h0000_0013;
        tick();
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h10) $display("FAIL ic_only_issue: rd=%b addr=%h want 1 00000010", mem_rd, mem_addr);
        else n_pass++;
        wr_seen += mem_wr;
        tick();
        wr_seen += mem_wr;
        n_checks++;
        if (mem_rd !== 1'b1 || ic_done !== 1'b0) $display("FAIL ic_only_hold: rd=%b done=%b want 1 0", mem_rd, ic_done);
        else n_pass++;
        mem_ready = 1'b1;
        mem_data  = IC_DATA0;
        tick();
        wr_seen += mem_wr;
        n_checks++;
        if (ic_done !== 1'b1 || dc_done !== 1'b0 || mem_rd !== 1'b0) $display("FAIL ic_only_done: ic_done=%b dc_done=%b rd=%b want 1 0 0", ic_done, dc_done, mem_rd);
        else n_pass++;
        n_checks++;
        if (ic_rdata !== IC_DATA0) $display("FAIL ic_only_rdata: got %h want %h", ic_rdata, IC_DATA0);
        else n_pass++;
        ic_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        wr_seen += mem_wr;
        n_checks++;
        if (ic_done !== 1'b0) $display("FAIL ic_only_single_pulse: ic_done=%b want 0", ic_done);
        else n_pass++;
        tick();
        wr_seen += mem_wr;
        n_checks++;
        if (wr_seen != 0) $display("FAIL ic_only_no_write: write_en seen %0d cycles want 0", wr_seen);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dc_addr = 32'h0000_0104;
        ic_addr = 32'h0000_020C;
        dc_we   = 1'b0;
        for (int r = 0; r < 2; r++) begin
            ic_req = 1'b1;
            dc_req = 1'b1;
            tick();
            n_checks++;
            if (mem_rd !== 1'b1 || mem_addr !== 32'h100) $display("FAIL rr_dc_first_r%0d: rd=%b addr=%h want 1 00000100", r, mem_rd, mem_addr);
            else n_pass++;
            mem_ready = 1'b1;
            mem_data  = D_DATA + LW'(r);
            tick();
            n_checks++;
            if (dc_done !== 1'b1 || ic_done !== 1'b0 || dc_rdata !== D_DATA + LW'(r))
                $display("FAIL rr_dc_done_r%0d: dc_done=%b ic_done=%b dc_rdata=%h want 1 0 %h", r, dc_done, ic_done, dc_rdata, D_DATA + LW'(r));
            else n_pass++;
            dc_req    = 1'b0;
            mem_ready = 1'b0;
            tick();
            n_checks++;
            if (mem_rd !== 1'b0) $display("FAIL rr_gap_r%0d: rd=%b want 0", r, mem_rd);
            else n_pass++;
            tick();
            n_checks++;
            if (mem_rd !== 1'b1 || mem_addr !== 32'h200) $display("FAIL rr_ic_second_r%0d: rd=%b addr=%h want 1 00000200", r, mem_rd, mem_addr);
            else n_pass++;
            mem_ready = 1'b1;
            mem_data  = I_DATA + LW'(r);
            tick();
            n_checks++;
            if (ic_done !== 1'b1 || dc_done !== 1'b0 || ic_rdata !== I_DATA + LW'(r))
                $display("FAIL rr_ic_done_r%0d: ic_done=%b dc_done=%b ic_rdata=%h want 1 0 %h", r, ic_done, dc_done, ic_rdata, I_DATA + LW'(r));
            else n_pass++;
            ic_req    = 1'b0;
            mem_ready = 1'b0;
            tick();
        end
    endtask

    task automatic test_writeback();
        logic [LW-1:0] prev = D_DATA + LW'(1);
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = 32'h0000_0024;
        dc_wdata = PAT_A;
        mem_data = ~PAT_A;
        tick();
        n_checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h20 || mem_wdata !== PAT_A)
            $display("FAIL wb_issue: wr=%b rd=%b addr=%h wdata=%h want 1 0 00000020 %h", mem_wr, mem_rd, mem_addr, mem_wdata, PAT_A);
        else n_pass++;
        tick();
        n_checks++;
        if (mem_wr !== 1'b1 || mem_wdata !== PAT_A) $display("FAIL wb_hold: wr=%b wdata=%h want 1 %h", mem_wr, mem_wdata, PAT_A);
        else n_pass++;
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if (dc_done !== 1'b1 || mem_wr !== 1'b0) $display("FAIL wb_done: dc_done=%b wr=%b want 1 0", dc_done, mem_wr);
        else n_pass++;
        n_checks++;
        if (dc_rdata !== prev) $display("FAIL wb_rdata_kept: got %h want %h", dc_rdata, prev);
        else n_pass++;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_ready_hold();
        int dones = 0;
        ic_req  = 1'b1;
        ic_addr = 32'h0000_0048;
        tick();
        mem_ready = 1'b1;
        mem_data  = I_DATA;
        tick();
        dones += ic_done;
        tick();
        dones += ic_done;
        n_checks++;
        if (mem_rd !== 1'b0) $display("FAIL hold_no_reissue_ready_high: rd=%b want 0", mem_rd);
        else n_pass++;
        mem_ready = 1'b0;
        tick();
        dones += ic_done;
        n_checks++;
        if (mem_rd !== 1'b0) $display("FAIL hold_gap: rd=%b want 0", mem_rd);
        else n_pass++;
        n_checks++;
        if (dones != 1) $display("FAIL hold_single_done: got %0d pulses want 1", dones);
        else n_pass++;
        tick();
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h40) $display("FAIL hold_reissue: rd=%b addr=%h want 1 00000040", mem_rd, mem_addr);
        else n_pass++;
        mem_ready = 1'b1;
        tick();
        ic_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h0000_0088;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || dc_done !== 1'b0) $display("FAIL rstmid_abort: rd=%b wr=%b dc_done=%b want 0 0 0", mem_rd, mem_wr, dc_done);
        else n_pass++;
        rst_n  = 1'b1;
        ic_req = 1'b1;
        ic_addr = 32'h0000_0300;
        tick();
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h80 || dc_done !== 1'b0) $display("FAIL rstmid_dc_wins: rd=%b addr=%h dc_done=%b want 1 00000080 0", mem_rd, mem_addr, dc_done);
        else n_pass++;
        mem_ready = 1'b1;
        mem_data  = D_DATA;
        tick();
        n_checks++;
        if (dc_done !== 1'b1 || ic_done !== 1'b0) $display("FAIL rstmid_dc_done: dc_done=%b ic_done=%b want 1 0", dc_done, ic_done);
        else n_pass++;
        dc_req    = 1'b0;
        ic_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int early = 0;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h0000_0400;
        tick();
`ifdef OFFCHIP_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            early += dc_done;
        end
        n_checks++;
        if (early != 0) $display("FAIL timeout_early: %0d done pulses before expiry want 0", early);
        else n_pass++;
        tick();
        n_checks++;
        if (dc_done !== 1'b1 || dc_err !== 1'b1 || dc_rdata !== '0 || mem_rd !== 1'b0)
            $display("FAIL timeout_expire: done=%b err=%b rdata=%h rd=%b want 1 1 0 0", dc_done, dc_err, dc_rdata, mem_rd);
        else n_pass++;
        dc_req = 1'b0;
        tick();
        n_checks++;
        if (dc_done !== 1'b0 || dc_err !== 1'b0) $display("FAIL timeout_pulse_len: done=%b err=%b want 0 0", dc_done, dc_err);
        else n_pass++;
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            early += dc_done | dc_err;
        end
        n_checks++;
        if (early != 0 || mem_rd !== 1'b1) $display("FAIL no_timeout_wait: done/err pulses=%0d rd=%b want 0 1", early, mem_rd);
        else n_pass++;
        mem_ready = 1'b1;
        mem_data  = PAT_A;
        tick();
        n_checks++;
        if (dc_done !== 1'b1 || dc_err !== 1'b0 || dc_rdata !== PAT_A)
            $display("FAIL no_timeout_late_done: done=%b err=%b rdata=%h want 1 0 %h", dc_done, dc_err, dc_rdata, PAT_A);
        else n_pass++;
        dc_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ic_req    = 1'b0;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        ic_addr   = '0;
        dc_addr   = '0;
        dc_wdata  = '0;
        mem_data  = '0;
        mem_ready = 1'b0;
        test_reset();
        test_ic_only();
        test_round_robin();
        test_writeback();
        test_ready_hold();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
